ifetch_unit: RTL

Fetch stage that sits directly upstream of the decode/control unit in the RV32I core. It owns the PC and fetches one instruction word at a time from instruction memory over a req/ack handshake. It holds that word stable, exposing the pre-sliced opcode/funct3/funct7 fields to the control unit, until the core signals commit. It then computes the next PC from the control outputs (pc_sel, trap) and the ALU result.

---
 rtl/ifetch_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: RV32I fetch stage. It owns the PC, fetches one instruction
// word over a req/ack handshake, holds it for decode until commit, then
// selects the next PC from trap / pc_sel / alu_result.
//
// Ports:
//   clk, rst_n            core clock (rising edge), async active-low reset
//   imem_req, imem_addr   fetch request; imem_addr == pc while requesting
//   imem_ack, imem_rdata  memory response; rdata valid in the ack cycle
//   commit                core retires the held instruction
//   pc_sel, trap          redirect controls, sampled on commit
//   alu_result            redirect target for pc_sel
//   pc, pc_plus4          held instruction address and its successor
//   instr, instr_valid    held instruction word and its valid flag
//   opcode, funct3,funct7 pre-sliced fields of instr
//   fault                 sticky misaligned-fetch fault
//   instret               retired-instruction counter
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0004,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        commit,
  input  logic        pc_sel,
  input  logic        trap,
  input  logic [31:0] alu_result,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [4:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7,
  output logic        fault,
  output logic [31:0] instret
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_EXEC  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  instr_q, instr_d;
  logic [XLEN-1:0]  instret_q, instret_d;
  logic [XLEN-1:0]  next_pc;
  logic             fetch_done;
  logic             retire;

  assign fetch_done = (state_q == ST_REQ) && imem_ack;
  assign retire     = (state_q == ST_EXEC) && commit;

  // Next-PC select: trap beats pc_sel; JALR targets have bit 0 cleared.
  always_comb begin
    if (trap) begin
      next_pc = TRAP_VEC;
    end else if (pc_sel) begin
      next_pc = {alu_result[XLEN-1:1], 1'b0};
    end else begin
      next_pc = pc_plus4;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_REQ;
      ST_REQ:   if (imem_ack) state_d = ST_EXEC;
      ST_EXEC:  if (commit) state_d = next_pc[1] ? ST_FAULT : ST_REQ;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode from the state register
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fault       = 1'b0;
    case (state_q)
      ST_REQ:   imem_req    = 1'b1;
      ST_EXEC:  instr_valid = 1'b1;
      ST_FAULT: fault       = 1'b1;
      default:  ;
    endcase
  end

  // Datapath next values; a faulting redirect keeps the old pc.
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    if (fetch_done) begin
      instr_d = imem_rdata;
    end
    if (retire) begin
      instr_d   = NOP_WORD;
      instret_d = instret_q + XLEN'(1);
      if (!next_pc[1]) begin
        pc_d = next_pc;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      instr_q   <= NOP_WORD;
      instret_q <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign pc_plus4  = pc_q + XLEN'(4);
  assign instr     = instr_q;
  assign instret   = instret_q;
  assign opcode    = instr_q[6:2];
  assign funct3    = instr_q[14:12];
  assign funct7    = instr_q[30];

endmodule
